// File: rtl/serial_shifter_pkg.sv
// serial_shifter_pkg: op encodings and FSM state encoding shared by the shifter files
package serial_shifter_pkg;
  localparam logic [2:0] OP_LSL  = 3'd0;
  localparam logic [2:0] OP_LSR  = 3'd1;
  localparam logic [2:0] OP_ASR  = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_HOLD = 3'd5;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/serial_shifter_shift_step.sv
// shift_step: one combinational 1-bit step of op on q; rotates only with SERIAL_SHIFTER_ROTATE_EN
module shift_step
  import serial_shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] w_lsl, w_lsr, w_asr, w_rol, w_ror;
  always_comb begin
    w_lsl = {q[WIDTH-2:0], 1'b0};
    w_lsr = {1'b0, q[WIDTH-1:1]};
    w_asr = {q[WIDTH-1], q[WIDTH-1:1]};
`ifdef SERIAL_SHIFTER_ROTATE_EN
    w_rol = {q[WIDTH-2:0], q[WIDTH-1]};
    w_ror = {q[0], q[WIDTH-1:1]};
`else
    w_rol = w_lsl;
    w_ror = w_lsr;
`endif
    y = op == OP_LSL ? w_lsl :
        op == OP_LSR ? w_lsr :
        op == OP_ASR ? w_asr :
        op == OP_ROL ? w_rol :
        op == OP_ROR ? w_ror : q;
  end
endmodule

// File: rtl/serial_shifter.sv
// serial_shifter: multi-cycle one-bit-per-clock shifter; SERIAL_SHIFTER_ROTATE_EN enables ROL/ROR
module serial_shifter
  import serial_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);
  state_e r_state, w_next;
  logic [WIDTH-1:0] r_q, w_step;
  logic [2:0] r_op;
  logic [AMT_W-1:0] r_cnt;
  logic w_accept;
  shift_step #(.WIDTH(WIDTH)) u_step (.op(r_op), .q(r_q), .y(w_step));
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_accept = start && r_state != SHIFT;
    w_next = IDLE;
    if (w_accept)
      w_next = amt != '0 ? SHIFT : DONE;
    else if (r_state == SHIFT)
      w_next = r_cnt == AMT_W'(1) ? DONE : SHIFT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q   <= '0;
      r_op  <= OP_LSL;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_q   <= d_in;
      r_op  <= op;
      r_cnt <= amt;
    end else if (r_state == SHIFT) begin
      r_q   <= w_step;
      r_cnt <= r_cnt - AMT_W'(1);
    end
  end
  assign q    = r_q;
  assign busy = r_state == SHIFT;
  assign done = r_state == DONE;
endmodule

// File: tb/tb_serial_shifter.sv
// tb_serial_shifter: scoreboard bench for serial_shifter at WIDTH=8
module tb_serial_shifter;
  logic clk = 0, reset = 1, start = 0;
  logic [2:0] op = 0;
  logic [2:0] amt = 0;
  logic [7:0] d_in = 0;
  logic [7:0] q;
  logic busy, done;
  int checks = 0, passed = 0;
  logic [7:0] exp_q[$];

  serial_shifter dut (.clk(clk), .reset(reset), .start(start), .op(op), .amt(amt),
                      .d_in(d_in), .q(q), .busy(busy), .done(done));

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] o, input int n);
    logic [7:0] v = d;
    for (int i = 0; i < n; i++) begin
      case (o)
        3'd0: v = v << 1;
        3'd1: v = v >> 1;
        3'd2: v = {v[7], v[7:1]};
`ifdef SERIAL_SHIFTER_ROTATE_EN
        3'd3: v = {v[6:0], v[7]};
        3'd4: v = {v[0], v[7:1]};
`else
        3'd3: v = v << 1;
        3'd4: v = v >> 1;
`endif
        default: v = v;
      endcase
    end
    return v;
  endfunction

  task automatic issue(input logic [7:0] d, input logic [2:0] o, input logic [2:0] a);
    start = 1; d_in = d; op = o; amt = a;
    exp_q.push_back(model(d, o, int'(a)));
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int budget, output int busy_cycles, output bit got);
    busy_cycles = 0; got = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin got = 1; break; end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1; start = 1; d_in = 8'hFF; amt = 3'd2;
    @(negedge clk); @(negedge clk);
    checks++; if (q !== 8'h00) $display("FAIL reset_q: got %h expected 00", q); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    reset = 0; start = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || q !== 8'h00) $display("FAIL reset_idle: busy %b q %h expected 0 00", busy, q); else passed++;
  endtask

  task automatic run_check(input string name, input logic [7:0] d, input logic [2:0] o, input logic [2:0] a);
    int bc; bit got; logic [7:0] e;
    issue(d, o, a);
    wait_done(int'(a) + 4, bc, got);
    e = exp_q.pop_front();
    checks++; if (!got) $display("FAIL %s_timeout: no done within %0d cycles", name, int'(a) + 4); else passed++;
    checks++; if (q !== e) $display("FAIL %s_q: got %h expected %h", name, q, e); else passed++;
    checks++; if (bc != int'(a)) $display("FAIL %s_busy: got %0d cycles expected %0d", name, bc, int'(a)); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b0 || q !== e) $display("FAIL %s_hold: done %b q %h expected 0 %h", name, done, q, e); else passed++;
  endtask

  task automatic test_lsl;
    run_check("lsl3", 8'b1001_0110, 3'd0, 3'd3);
    checks++; if (q !== 8'b1011_0000) $display("FAIL lsl3_const: got %h expected b0", q); else passed++;
  endtask

  task automatic test_asr_lsr;
    run_check("asr2", 8'b1001_0110, 3'd2, 3'd2);
    checks++; if (q !== 8'b1110_0101) $display("FAIL asr2_const: got %h expected e5", q); else passed++;
    run_check("lsr2", 8'b1001_0110, 3'd1, 3'd2);
    checks++; if (q !== 8'b0010_0101) $display("FAIL lsr2_const: got %h expected 25", q); else passed++;
  endtask

  task automatic test_rotate;
    run_check("rol1", 8'b1000_0001, 3'd3, 3'd1);
    run_check("ror1", 8'b1000_0001, 3'd4, 3'd1);
    run_check("rol7", 8'b1100_0001, 3'd3, 3'd7);
  endtask

  task automatic test_hold_and_max;
    run_check("hold5", 8'h5A, 3'd5, 3'd5);
    run_check("hold7op", 8'h3C, 3'd7, 3'd2);
    run_check("asr7", 8'h80, 3'd2, 3'd7);
    run_check("lsl7", 8'hFF, 3'd0, 3'd7);
  endtask

  task automatic test_back_to_back;
    int bc; bit got; logic [7:0] e;
    issue(8'hA5, 3'd0, 3'd0);
    e = exp_q.pop_front();
    checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL amt0_done: done %b busy %b expected 1 0", done, busy); else passed++;
    checks++; if (q !== e) $display("FAIL amt0_q: got %h expected %h", q, e); else passed++;
    issue(8'h3C, 3'd0, 3'd1);
    checks++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b expected 1", busy); else passed++;
    wait_done(5, bc, got);
    e = exp_q.pop_front();
    checks++; if (!got) $display("FAIL b2b_timeout: no done within 5 cycles"); else passed++;
    checks++; if (q !== e) $display("FAIL b2b_q: got %h expected %h", q, e); else passed++;
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int bc; bit got; logic [7:0] e;
    issue(8'b1001_0110, 3'd0, 3'd3);
    start = 1; d_in = 8'hFF; op = 3'd4; amt = 3'd1;
    @(negedge clk);
    start = 0;
    wait_done(6, bc, got);
    e = exp_q.pop_front();
    checks++; if (!got) $display("FAIL ignore_timeout: no done within 6 cycles"); else passed++;
    checks++; if (q !== e) $display("FAIL ignore_q: got %h expected %h", q, e); else passed++;
    checks++; if (bc != 2) $display("FAIL ignore_busy: got %0d remaining cycles expected 2", bc); else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift;
    int seen = 0;
    issue(8'b1001_0110, 3'd0, 3'd3);
    void'(exp_q.pop_front());
    reset = 1;
    @(negedge clk);
    reset = 0;
    checks++; if (q !== 8'h00 || busy !== 1'b0) $display("FAIL midreset: q %h busy %b expected 00 0", q, busy); else passed++;
    for (int i = 0; i < 5; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) $display("FAIL midreset_done: got %0d pulses expected 0", seen); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_lsl;
    test_asr_lsr;
    test_rotate;
    test_hold_and_max;
    test_back_to_back;
    test_ignore_start;
    test_reset_mid_shift;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
